// File: rtl/vec_stream_pkg.sv
// Package for the vector sample drain.
// Holds the vector/lane geometry, the unpacker state encoding and the
// vector word type shared by the top level and the FIFO user.
package vec_stream_pkg;
  localparam int VEC_W  = 128;
  localparam int LANE_W = 16;
  localparam int LANES  = VEC_W / LANE_W;

  typedef enum logic {IDLE, STREAM} drain_state_t;
  typedef logic [VEC_W-1:0] vec_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a count-based full/empty.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   write request and data
//   pop               read request; head advances at the clock edge
//   head_data         current head word, valid while !empty
//   full, empty       status derived from the occupancy count
//   level             occupancy count, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign level     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO
  // is still accepted when it coincides with a pop.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/vec_sample_drain.sv
// Vector sample drain.
// Captures 128-bit vector stores that land in an address window, queues
// them, and streams each word out lane by lane (lane 0 first) on a
// valid/ready interface. The core cannot be stalled, so a store that
// finds the queue full is dropped and flagged in a sticky overflow bit.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   wren_b, addr_b, data_b        core vector store port
//   out_valid/out_ready           sample stream handshake
//   out_sample, out_last          current lane, last-lane marker
//   fifo_level                    queued words (excludes the held word)
//   overflow, clear_ovf           sticky drop flag and its clear
module vec_sample_drain
  import vec_stream_pkg::VEC_W, vec_stream_pkg::vec_t,
         vec_stream_pkg::drain_state_t, vec_stream_pkg::IDLE,
         vec_stream_pkg::STREAM;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] WIN_BASE = 'h0400,
  parameter logic [ADDR_W-1:0] WIN_SIZE = 'h0010,
  parameter int                DEPTH    = 8,
  parameter int                LANE_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wren_b,
  input  logic [ADDR_W-1:0]      addr_b,
  input  logic [VEC_W-1:0]       data_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANE_W-1:0]      out_sample,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  input  logic                   clear_ovf
);
  localparam int LANES  = VEC_W / LANE_W;
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);

  // Window decode; the end address is one bit wider so a window that
  // touches the top of the address space does not wrap.
  logic [ADDR_W:0] win_end;
  logic            hit;
  assign win_end = {1'b0, WIN_BASE} + {1'b0, WIN_SIZE};
  assign hit     = wren_b && (addr_b >= WIN_BASE) && ({1'b0, addr_b} < win_end);

  vec_t fifo_head;
  logic fifo_full, fifo_empty, fifo_pop;

  sync_fifo #(.WIDTH(VEC_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (hit),
    .push_data (data_b),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Overflow: a set in the same cycle as a clear keeps the flag high.
  logic ovf_q, ovf_d, ovf_set;
  assign ovf_set = hit && fifo_full && !fifo_pop;
  assign overflow = ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set)        ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  // Unpacker
  drain_state_t      state_q, state_d;
  vec_t              hold_q, hold_d;
  logic [LIDX_W-1:0] lane_q, lane_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      lane_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      lane_q  <= lane_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state; the last-lane transfer reloads from the FIFO directly so
  // consecutive vectors stream without a bubble.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    lane_d   = lane_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_head;
          lane_d   = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (lane_q == LAST_LANE) begin
            lane_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              hold_d   = fifo_head;
            end else begin
              state_d = IDLE;
            end
          end else begin
            lane_d = lane_q + LIDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are driven from registered state only, so they stay stable
  // under backpressure.
  always_comb begin
    out_valid  = 1'b0;
    out_sample = '0;
    out_last   = 1'b0;
    if (state_q == STREAM) begin
      out_valid  = 1'b1;
      out_sample = hold_q[lane_q*LANE_W +: LANE_W];
      out_last   = (lane_q == LAST_LANE);
    end
  end
endmodule

// File: tb/tb_vec_sample_drain.sv
module tb_vec_sample_drain;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wren_b = 1'b0;
  logic [31:0]  addr_b = '0;
  logic [127:0] data_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [15:0]  out_sample;
  logic         out_last;
  logic [3:0]   fifo_level;
  logic         overflow;
  logic         clear_ovf = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vec_sample_drain dut (
    .clk(clk), .reset(reset), .wren_b(wren_b), .addr_b(addr_b), .data_b(data_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .out_last(out_last), .fifo_level(fifo_level), .overflow(overflow),
    .clear_ovf(clear_ovf)
  );

  // Lane k of the vector holds base+k.
  function automatic logic [127:0] mk(input int base);
    logic [127:0] v;
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = 16'(base + k);
    return v;
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step; step;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    tests_run++;
    if (out_sample !== 16'h0) begin tests_failed++; $display("FAIL reset_sample: got %0h want 0", out_sample); end
    tests_run++;
    if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_last: got %0b want 0", out_last); end
    tests_run++;
    if (fifo_level !== 4'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
    reset = 1'b0;
    step;
  endtask

  task automatic test_single;
    out_ready = 1'b1;
    wren_b = 1'b1; addr_b = 32'h0400; data_b = mk(1);
    step;
    wren_b = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || fifo_level !== 4'd1) begin
      tests_failed++; $display("FAIL single_lat1: valid=%0b level=%0d want 0/1", out_valid, fifo_level);
    end
    step;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_sample !== 16'(i+1) || out_last !== (i == 7)) begin
        tests_failed++;
        $display("FAIL single_lane%0d: valid=%0b sample=%0h last=%0b want 1/%0h/%0b",
                 i, out_valid, out_sample, out_last, i+1, (i == 7));
      end
      step;
    end
    tests_run++;
    if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
      tests_failed++; $display("FAIL single_idle: valid=%0b level=%0d want 0/0", out_valid, fifo_level);
    end
  endtask

  task automatic test_miss;
    out_ready = 1'b1;
    wren_b = 1'b1; addr_b = 32'h0410; data_b = mk(50);
    step;
    addr_b = 32'h03FF;
    step;
    wren_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
        tests_failed++; $display("FAIL miss_%0d: valid=%0b level=%0d want 0/0", i, out_valid, fifo_level);
      end
      step;
    end
    // Top address of the window is a hit.
    wren_b = 1'b1; addr_b = 32'h040F; data_b = mk(200);
    step;
    wren_b = 1'b0;
    tests_run++;
    if (fifo_level !== 4'd1) begin tests_failed++; $display("FAIL edge_hit_level: got %0d want 1", fifo_level); end
    step;
    tests_run++;
    if (out_valid !== 1'b1 || out_sample !== 16'd200) begin
      tests_failed++; $display("FAIL edge_hit_sample: valid=%0b sample=%0d want 1/200", out_valid, out_sample);
    end
    for (int i = 0; i < 8; i++) step;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL edge_hit_idle: got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b1;
    wren_b = 1'b1; addr_b = 32'h0400; data_b = mk(1);
    step;
    wren_b = 1'b0;
    step;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (out_sample !== 16'(i+1)) begin tests_failed++; $display("FAIL bp_pre%0d: got %0h want %0h", i, out_sample, i+1); end
      step;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_sample !== 16'd4 || out_last !== 1'b0) begin
        tests_failed++; $display("FAIL bp_hold%0d: valid=%0b sample=%0h last=%0b want 1/4/0", i, out_valid, out_sample, out_last);
      end
      step;
    end
    out_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_sample !== 16'(i+1) || out_last !== (i == 7)) begin
        tests_failed++; $display("FAIL bp_post%0d: valid=%0b sample=%0h last=%0b want 1/%0h/%0b", i, out_valid, out_sample, out_last, i+1, (i == 7));
      end
      step;
    end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_idle: got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 27; cyc++) begin
      if (cyc < 3) begin
        wren_b = 1'b1; addr_b = 32'h0400 + 32'(cyc); data_b = mk(1 + 8*cyc);
      end else begin
        wren_b = 1'b0;
      end
      if (cyc >= 2 && cyc < 26) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_sample !== 16'(cyc-1) || out_last !== ((cyc-2) % 8 == 7)) begin
          tests_failed++;
          $display("FAIL b2b_%0d: valid=%0b sample=%0d last=%0b want 1/%0d/%0b",
                   cyc-2, out_valid, out_sample, out_last, cyc-1, ((cyc-2) % 8 == 7));
        end
      end
      if (cyc == 26) begin
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got %0b want 0", out_valid); end
      end
      step;
    end
  endtask

  task automatic test_overflow;
    out_ready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      wren_b = 1'b1; addr_b = 32'h0400; data_b = mk(1 + 8*j);
      step;
      if (j == 8) begin
        tests_run++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
          tests_failed++; $display("FAIL ovf_fill: level=%0d ovf=%0b want 8/0", fifo_level, overflow);
        end
      end
    end
    wren_b = 1'b0;
    tests_run++;
    if (fifo_level !== 4'd8 || overflow !== 1'b1 || out_sample !== 16'd1) begin
      tests_failed++; $display("FAIL ovf_drop: level=%0d ovf=%0b sample=%0d want 8/1/1", fifo_level, overflow, out_sample);
    end
    wren_b = 1'b1; data_b = mk(81); clear_ovf = 1'b1;
    step;
    wren_b = 1'b0; clear_ovf = 1'b0;
    tests_run++;
    if (overflow !== 1'b1 || fifo_level !== 4'd8) begin
      tests_failed++; $display("FAIL ovf_set_wins: ovf=%0b level=%0d want 1/8", overflow, fifo_level);
    end
    clear_ovf = 1'b1;
    step;
    clear_ovf = 1'b0;
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
    // Drain; a store on the last-lane pop while full must be accepted.
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      wren_b = (cyc == 7); addr_b = 32'h0400; data_b = mk(73);
      tests_run++;
      if (out_valid !== 1'b1 || out_sample !== 16'(cyc+1) || out_last !== (cyc % 8 == 7)) begin
        tests_failed++;
        $display("FAIL ovf_drain%0d: valid=%0b sample=%0d last=%0b want 1/%0d/%0b",
                 cyc, out_valid, out_sample, out_last, cyc+1, (cyc % 8 == 7));
      end
      if (cyc == 8) begin
        tests_run++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
          tests_failed++; $display("FAIL full_push_pop: level=%0d ovf=%0b want 8/0", fifo_level, overflow);
        end
      end
      step;
    end
    wren_b = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || fifo_level !== 4'd0) begin
      tests_failed++; $display("FAIL ovf_end: valid=%0b ovf=%0b level=%0d want 0/0/0", out_valid, overflow, fifo_level);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      wren_b = 1'b1; addr_b = 32'h0400; data_b = mk(1 + 8*j);
      step;
    end
    wren_b = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step;
    tests_run++;
    if (out_sample !== 16'd6 || fifo_level !== 4'd3) begin
      tests_failed++; $display("FAIL rmid_pre: sample=%0d level=%0d want 6/3", out_sample, fifo_level);
    end
    reset = 1'b1;
    step;
    tests_run++;
    if (out_valid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0 || out_sample !== 16'd0 || out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_reset: valid=%0b level=%0d ovf=%0b sample=%0h last=%0b want all 0",
               out_valid, fifo_level, overflow, out_sample, out_last);
    end
    reset = 1'b0;
    step; step;
    tests_run++;
    if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
      tests_failed++; $display("FAIL rmid_after: valid=%0b level=%0d want 0/0", out_valid, fifo_level);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_miss;
    test_backpressure;
    test_back_to_back;
    test_overflow;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
